// File: rtl/application_selector_cpu_oci_trace_packer.sv
// Packs variable-count OCI debug-trace slot bursts LSB-first into fixed-width words,
// buffers them in a show-ahead FIFO and handles the end-of-test flush handshake.
//
// state  | meaning
// RUN    | accepting dct bursts, pushing each completed word
// FLUSH  | one cycle: push the partial accumulator, zero-padded, if non-empty
// DRAIN  | capture closed, waiting for readers to empty the FIFO
// DONE   | test_has_ended asserted until reset
module application_selector_cpu_oci_trace_packer #(
    parameter int SLOT_W     = 2,
    parameter int IN_SLOTS   = 15,
    parameter int CNT_W      = 4,
    parameter int WORD_SLOTS = 16,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         dct_valid,
    input  logic [IN_SLOTS*SLOT_W-1:0]   dct_buffer,
    input  logic [CNT_W-1:0]             dct_count,
    input  logic                         test_ending,
    input  logic                         rd_en,
    output logic [WORD_SLOTS*SLOT_W-1:0] rd_data,
    output logic                         rd_valid,
    output logic [ADDR_W:0]              fill_level,
    output logic                         overflow,
    output logic [15:0]                  drop_count,
    output logic                         test_has_ended
);

    localparam int WW   = WORD_SLOTS * SLOT_W;
    localparam int IW   = IN_SLOTS * SLOT_W;
    localparam int CW   = 2 * WW;
    localparam int AC_W = $clog2(WORD_SLOTS);
    localparam int T_W  = $clog2(2 * WORD_SLOTS);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t            state;
    logic [WW-1:0]     acc;
    logic [AC_W-1:0]   acc_cnt;
    logic [WW-1:0]     mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;

    logic [CNT_W-1:0]  n_eff;
    logic [IW-1:0]     new_slots;
    logic [CW-1:0]     ext_new;
    logic [CW-1:0]     merged;
    logic [T_W-1:0]    t_sum;
    logic              accept;
    logic              push_req;
    logic [WW-1:0]     push_word;
    logic [WW-1:0]     acc_nxt;
    logic [AC_W-1:0]   acc_cnt_nxt;
    logic              full;
    logic              pop;
    logic              wr_en;
    logic              drop;

    // Slots at or above the effective count are zeroed so the accumulator
    // never carries stale bits above acc_cnt; FLUSH relies on this for padding.
    always_comb begin
        n_eff = (dct_count > CNT_W'(IN_SLOTS)) ? CNT_W'(IN_SLOTS) : dct_count;
        new_slots = '0;
        for (int k = 0; k < IN_SLOTS; k++) begin
            if (k < int'(n_eff)) begin
                new_slots[k*SLOT_W +: SLOT_W] = dct_buffer[k*SLOT_W +: SLOT_W];
            end
        end
        ext_new = '0;
        ext_new[IW-1:0] = new_slots;
        merged = {{WW{1'b0}}, acc} | (ext_new << (acc_cnt * SLOT_W));
        t_sum  = T_W'(acc_cnt) + T_W'(n_eff);
    end

    assign accept = (state == ST_RUN) && dct_valid && (n_eff != '0);

    always_comb begin
        push_req    = 1'b0;
        push_word   = merged[WW-1:0];
        acc_nxt     = acc;
        acc_cnt_nxt = acc_cnt;
        if (accept) begin
            if (t_sum >= T_W'(WORD_SLOTS)) begin
                push_req    = 1'b1;
                acc_nxt     = merged[CW-1:WW];
                acc_cnt_nxt = AC_W'(t_sum - T_W'(WORD_SLOTS));
            end else begin
                acc_nxt     = merged[WW-1:0];
                acc_cnt_nxt = AC_W'(t_sum);
            end
        end else if (state == ST_FLUSH) begin
            push_req    = (acc_cnt != '0);
            push_word   = acc;
            acc_nxt     = '0;
            acc_cnt_nxt = '0;
        end
    end

    assign full     = (count == (ADDR_W+1)'(DEPTH));
    assign rd_valid = (count != '0);
    assign pop      = rd_en && rd_valid;
    // A push into a full FIFO survives only if the head leaves on the same edge.
    assign wr_en    = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    assign rd_data    = rd_valid ? mem[rd_ptr] : '0;
    assign fill_level = count;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_RUN;
            acc            <= '0;
            acc_cnt        <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            overflow       <= 1'b0;
            drop_count     <= '0;
            test_has_ended <= 1'b0;
        end else begin
            acc     <= acc_nxt;
            acc_cnt <= acc_cnt_nxt;

            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !pop) begin
                count <= count + 1'b1;
            end else if (!wr_en && pop) begin
                count <= count - 1'b1;
            end

            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end

            unique case (state)
                ST_RUN: begin
                    if (test_ending) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if ((count == '0) && !push_req) begin
                        state          <= ST_DONE;
                        test_has_ended <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule
